pll_clk_monitor: RTL and testbench
==================================

// Module: pll_clk_monitor
// PURPOSE
//  Sits directly downstream of the GW1N-9 rPLL wrapper. Runs on the 50 MHz board clock that feeds the PLL.
//  Counts rising edges of the PLL divided output (clkoutd, ~2.679 MHz) over a fixed gate window.
//  Each window's count is checked against an expected value with a tolerance.
//  The block generates clk_ok and a sequenced active-high reset (rst_out) for the TDC/ADC logic.
//  This replaces the PLL LOCK pin, which the wrapper does not export.
// PARAMETERS
//  GATE_CYCLES  50000  clk cycles per measurement window (1 ms at 50 MHz)
//  EXPECTED     2679   nominal clkoutd rising edges per window
//  TOL          8      allowed |count-EXPECTED| (inclusive)
//  GOOD_WINDOWS 3      consecutive passing windows required before clk_ok asserts
//  CNT_W        16     edge-counter width
// PORTS
//  clk        in   1      50 MHz reference clock (same net as PLL clkin)
//  rst        in   1      async active-high reset
//  meas_clk   in   1      PLL clkoutd; treated as asynchronous data, never used as a clock
//  clk_ok     out  1      measured frequency qualified
//  rst_out    out  1      active-high reset to downstream logic; asserted whenever clk_ok=0
//  win_done   out  1      1-cycle pulse when a window closes
//  fail       out  1      1-cycle pulse when a closed window is out of tolerance
// BEHAVIOUR
//  Reset values:
//   - clk_ok=0, rst_out=1, win_done=0, fail=0.
//   - All counters are 0. The state is FLUSH.
//  Input path:
//   - 2-FF synchroniser on meas_clk, then a 3rd FF for edge detection.
//   - edge = s2 & ~s3.
//   - Valid only for meas_clk < clk/2; faster inputs alias, which is acceptable because the check then fails.
//  State machine:
//   - FLUSH: wait 4 cycles so the synchroniser settles. No edges are counted. Then go to MEAS with gate=0, edges=0.
//   - MEAS: gate increments every cycle. edges increments on each edge and saturates at 2^CNT_W-1.
//     - On the cycle where gate==GATE_CYCLES-1, an edge seen that same cycle is included.
//     - Latch the final count, then go to EVAL.
//   - EVAL (1 cycle):
//     - win_done=1.
//     - pass = (count >= EXPECTED-TOL) && (count <= EXPECTED+TOL). Compare in CNT_W+1 bits; floor EXPECTED-TOL at 0.
//     - On pass: good_cnt = min(good_cnt+1, GOOD_WINDOWS).
//     - On fail: good_cnt=0, fail=1.
//     - Clear gate and edges, then return to MEAS. The next window starts the following cycle.
//     - Window period is GATE_CYCLES+1 clk cycles.
//  Outputs:
//   - clk_ok is registered: set on the cycle after an EVAL in which good_cnt reaches GOOD_WINDOWS.
//     Cleared on the cycle after any failing EVAL (single-window loss detection).
//   - rst_out = ~clk_ok, registered.
//     - Deassertion is synchronous to clk, one cycle after clk_ok rises.
//     - Assertion also happens on async rst.
//  Boundaries:
//   - meas_clk stuck at 0 or 1: count=0 -> fail every window, clk_ok stays 0.
//   - Saturated counter: treated as fail.
//   - rst mid-window: everything returns to reset values. Restart from FLUSH after rst releases.
//   - A partial window is never evaluated.
//  Latency: first clk_ok >= 4 + GOOD_WINDOWS*(GATE_CYCLES+1) cycles after rst release.
// CONFIGURATION
//  CLKMON_COUNT_OUT_EN defined:
//   - Adds output last_count [CNT_W-1:0], the count latched at the most recent EVAL.
//   - Reset value 0; updated on the EVAL cycle, together with win_done. Used for PLL bring-up debug.
//  CLKMON_COUNT_OUT_EN undefined:
//   - The port is absent and the latch register is not built. All other behaviour is identical.
// TESTING (GATE_CYCLES=1000, EXPECTED=50, TOL=2, GOOD_WINDOWS=3 unless noted)
//  - meas_clk period 20 clk, rst released at t0:
//    win_done every 1001 cycles, fail never.
//    clk_ok=1 and rst_out=0 at t0+4+3003+1 (+1 for rst_out).
//  - meas_clk stuck 0: fail pulses each window, count=0, clk_ok and rst_out hold 0 and 1 forever.
//  - Locked state, then period changed to 25 (40 edges):
//    first failing EVAL -> fail=1, clk_ok->0, rst_out->1 next cycle.
//    Restore period 20 -> 3 windows, then clk_ok=1 again.
//  - Tolerance edges: 48 and 52 edges/window -> pass; 47 and 53 -> fail.
//    Edge landing on gate==999 is counted in that window.
//  - Assert rst for 3 cycles mid-window while locked:
//    outputs return to reset values immediately.
//    No win_done until a full window completes after FLUSH.
//  - With CLKMON_COUNT_OUT_EN: last_count=50 after each window at period 20, 0 after reset.
//    Without it: compile with no last_count port.

Source files
------------

// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor
//   Qualifies the rPLL divided output (clkoutd) by counting its rising edges
//   on the 50 MHz reference clock over a fixed gate window. It stands in for
//   the PLL LOCK pin, which the wrapper does not export.
//
//   Each window lasts GATE_CYCLES measurement cycles plus one evaluation
//   cycle. clk_ok is raised after GOOD_WINDOWS consecutive in-tolerance
//   windows and dropped after any single failing window. rst_out is the
//   registered inverse of clk_ok and is meant to hold the TDC/ADC logic in
//   reset.
//
// Ports
//   clk        in   50 MHz reference clock (same net as the PLL clkin)
//   rst        in   asynchronous active-high reset
//   meas_clk   in   PLL clkoutd, sampled as asynchronous data
//   clk_ok     out  measured frequency qualified
//   rst_out    out  active-high reset to downstream logic (~clk_ok, registered)
//   win_done   out  1-cycle pulse when a window closes
//   fail       out  1-cycle pulse when a closed window is out of tolerance
//   last_count out  count of the most recent window (CLKMON_COUNT_OUT_EN only)
//
// Configuration
//   CLKMON_COUNT_OUT_EN  when defined, adds the last_count output and the
//                        register that holds it.

module pll_clk_monitor #(
    parameter int unsigned GATE_CYCLES  = 50000,
    parameter int unsigned EXPECTED     = 2679,
    parameter int unsigned TOL          = 8,
    parameter int unsigned GOOD_WINDOWS = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas_clk,
    output logic             clk_ok,
    output logic             rst_out,
    output logic             win_done,
    output logic             fail
`ifdef CLKMON_COUNT_OUT_EN
    ,
    output logic [CNT_W-1:0] last_count
`endif
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int unsigned GOOD_W = $clog2(GOOD_WINDOWS + 1);

    // Tolerance bounds are compared one bit wider than the counter so that
    // EXPECTED+TOL cannot wrap; the lower bound floors at zero.
    localparam logic [CNT_W:0] LO_BOUND =
        (EXPECTED > TOL) ? (CNT_W + 1)'(EXPECTED - TOL) : '0;
    localparam logic [CNT_W:0] HI_BOUND = (CNT_W + 1)'(EXPECTED + TOL);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(GOOD_WINDOWS);
    localparam logic [GATE_W-1:0] GATE_END = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        StFlush,
        StMeas,
        StEval
    } state_e;

    state_e              state_q;
    logic [1:0]          flush_q;
    logic [GATE_W-1:0]   gate_q;
    logic [CNT_W-1:0]    edges_q;
    logic [GOOD_W-1:0]   good_q;
    logic                clk_ok_q;
    logic                rst_out_q;
    logic                win_done_q;
    logic                fail_q;

    logic                sync1_q;
    logic                sync2_q;
    logic                sync3_q;

    logic                meas_edge;
    logic [CNT_W-1:0]    edges_inc;
    logic [CNT_W:0]      count_ext;
    logic                in_tol;
    logic [GOOD_W-1:0]   good_inc;
    logic                gate_last;

    // Two-stage synchroniser plus a third stage for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= meas_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign meas_edge = sync2_q & ~sync3_q;

    // Count including this cycle's edge, so an edge on the last gate cycle
    // still lands in the window being closed.
    always_comb begin
        edges_inc = edges_q;
        if (meas_edge && (edges_q != CNT_MAX)) begin
            edges_inc = edges_q + CNT_W'(1);
        end
        count_ext = {1'b0, edges_inc};
        // A saturated counter means the true count is unknown: never a pass.
        in_tol    = (count_ext >= LO_BOUND) && (count_ext <= HI_BOUND) &&
                    (edges_inc != CNT_MAX);
        good_inc  = (good_q >= GOOD_MAX) ? GOOD_MAX : good_q + GOOD_W'(1);
        gate_last = (gate_q == GATE_END);
    end

    // Window sequencer. The pass/fail decision is taken on the last gate
    // cycle and registered, so win_done, fail and the updated good count are
    // all visible during the single EVAL cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFlush;
            flush_q    <= '0;
            gate_q     <= '0;
            edges_q    <= '0;
            good_q     <= '0;
            clk_ok_q   <= 1'b0;
            rst_out_q  <= 1'b1;
            win_done_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            win_done_q <= 1'b0;
            fail_q     <= 1'b0;
            rst_out_q  <= ~clk_ok_q;
            unique case (state_q)
                StFlush: begin
                    if (flush_q == 2'd3) begin
                        state_q <= StMeas;
                        gate_q  <= '0;
                        edges_q <= '0;
                    end else begin
                        flush_q <= flush_q + 2'd1;
                    end
                end
                StMeas: begin
                    gate_q  <= gate_q + GATE_W'(1);
                    edges_q <= edges_inc;
                    if (gate_last) begin
                        state_q    <= StEval;
                        win_done_q <= 1'b1;
                        if (in_tol) begin
                            good_q <= good_inc;
                        end else begin
                            good_q <= '0;
                            fail_q <= 1'b1;
                        end
                    end
                end
                StEval: begin
                    // good_q already reflects this window; a fail has zeroed it.
                    clk_ok_q <= (good_q == GOOD_MAX);
                    gate_q   <= '0;
                    edges_q  <= '0;
                    state_q  <= StMeas;
                end
                default: begin
                    state_q <= StFlush;
                    flush_q <= '0;
                end
            endcase
        end
    end

`ifdef CLKMON_COUNT_OUT_EN
    logic [CNT_W-1:0] last_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_count_q <= '0;
        end else if ((state_q == StMeas) && gate_last) begin
            last_count_q <= edges_inc;
        end
    end

    assign last_count = last_count_q;
`endif

    assign clk_ok   = clk_ok_q;
    assign rst_out  = rst_out_q;
    assign win_done = win_done_q;
    assign fail     = fail_q;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Directed bench for pll_clk_monitor with GATE_CYCLES=1000, EXPECTED=50,
// TOL=2, GOOD_WINDOWS=3. meas_clk pulses are placed relative to the EVAL
// cycle so every window carries an exact, hand-chosen edge count.

module tb_pll_clk_monitor;

    localparam int unsigned GATE = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        meas_clk = 1'b0;
    logic        clk_ok;
    logic        rst_out;
    logic        win_done;
    logic        fail;
`ifdef CLKMON_COUNT_OUT_EN
    logic [15:0] last_count;
`endif

    int checks = 0;
    int failures = 0;

    // Bench model of the qualification state.
    int good = 0;
    bit exp_ok = 1'b0;
    bit prev_ok = 1'b0;

    pll_clk_monitor #(
        .GATE_CYCLES (GATE),
        .EXPECTED    (50),
        .TOL         (2),
        .GOOD_WINDOWS(3),
        .CNT_W       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .meas_clk(meas_clk),
        .clk_ok  (clk_ok),
        .rst_out (rst_out),
        .win_done(win_done),
        .fail    (fail)
`ifdef CLKMON_COUNT_OUT_EN
        ,
        .last_count(last_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered on the negedge of an EVAL cycle; returns on the negedge of the
    // next EVAL cycle. Pulses start every 18 cycles (n of them); 'extra' adds
    // one more whose edge reaches the counter on the last gate cycle.
    task automatic run_window(input int n, input bit extra, input bit exp_fail);
        for (int c = 0; c <= GATE; c++) begin
            meas_clk = ((c < 18 * n) && ((c % 18) < 4)) || (extra && c >= 998 && c < 1000);
            if (c == 1) begin
                check_eq("clk_ok_after_eval", 32'(clk_ok), 32'(exp_ok));
                check_eq("rst_out_lag", 32'(rst_out), 32'(!prev_ok));
                check_eq("win_done_pulse_width", 32'(win_done), 0);
                check_eq("fail_pulse_width", 32'(fail), 0);
            end
            if (c == 2) check_eq("rst_out_follow", 32'(rst_out), 32'(!exp_ok));
            @(negedge clk);
        end
        meas_clk = 1'b0;
        check_eq("win_done_at_eval", 32'(win_done), 1);
        check_eq($sformatf("fail_n%0d", n + int'(extra)), 32'(fail), 32'(exp_fail));
`ifdef CLKMON_COUNT_OUT_EN
        check_eq("last_count", 32'(last_count), 32'(n + int'(extra)));
`endif
        prev_ok = exp_ok;
        if (exp_fail) good = 0;
        else if (good < 3) good++;
        exp_ok = (good == 3);
    endtask

    initial begin
        int k;
        int wd_idx;
        int fail_seen;
        int ok_at;
        int rl_at;
        int wd_at;
        int early_wd;
        int wd_exp[4];

        wd_exp = '{1004, 2005, 3006, 4007};

        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst_clk_ok", 32'(clk_ok), 0);
        check_eq("rst_rst_out", 32'(rst_out), 1);
        check_eq("rst_win_done", 32'(win_done), 0);
        check_eq("rst_fail", 32'(fail), 0);
`ifdef CLKMON_COUNT_OUT_EN
        check_eq("rst_last_count", 32'(last_count), 0);
`endif

        // Free-running period-20 input from release: window timing and lock.
        rst = 1'b0;
        k = 0;
        wd_idx = 0;
        fail_seen = 0;
        ok_at = 0;
        rl_at = 0;
        while (k < 4007) begin
            @(negedge clk);
            k++;
            if (win_done) begin
                if (wd_idx < 4) check_eq($sformatf("win_done_time%0d", wd_idx), k, wd_exp[wd_idx]);
                else check_eq("win_done_extra", k, 0);
`ifdef CLKMON_COUNT_OUT_EN
                check_eq("last_count_free", 32'(last_count), 50);
`endif
                wd_idx++;
            end
            if (fail) fail_seen++;
            if (clk_ok && ok_at == 0) ok_at = k;
            if (!rst_out && rl_at == 0) rl_at = k;
            meas_clk = (k % 20) >= 10;
        end
        check_eq("win_done_count", wd_idx, 4);
        check_eq("fail_never", fail_seen, 0);
        check_eq("clk_ok_rise_time", ok_at, 3007);
        check_eq("rst_out_fall_time", rl_at, 3008);

        // Locked; now at the EVAL cycle of the fourth window.
        good = 3;
        exp_ok = 1'b1;
        prev_ok = 1'b1;
        run_window(50, 1'b0, 1'b0);
        run_window(48, 1'b0, 1'b0);
        run_window(52, 1'b0, 1'b0);
        run_window(47, 1'b0, 1'b1);
        run_window(53, 1'b0, 1'b1);
        run_window(50, 1'b0, 1'b0);
        run_window(50, 1'b0, 1'b0);
        run_window(50, 1'b0, 1'b0);
        run_window(40, 1'b0, 1'b1);
        run_window(47, 1'b1, 1'b0);
        run_window(0, 1'b0, 1'b1);
        run_window(0, 1'b0, 1'b1);
        run_window(50, 1'b0, 1'b0);
        run_window(50, 1'b0, 1'b0);
        run_window(50, 1'b0, 1'b0);
        run_window(50, 1'b0, 1'b0);
        check_eq("relocked", 32'(exp_ok), 1);

        // Mid-window reset while locked.
        for (int c = 0; c < 300; c++) begin
            meas_clk = (c % 20) >= 10;
            @(negedge clk);
        end
        check_eq("pre_reset_clk_ok", 32'(clk_ok), 1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_clk_ok", 32'(clk_ok), 0);
        check_eq("async_rst_rst_out", 32'(rst_out), 1);
        check_eq("async_rst_win_done", 32'(win_done), 0);
        repeat (3) @(negedge clk);
`ifdef CLKMON_COUNT_OUT_EN
        check_eq("rst_last_count_mid", 32'(last_count), 0);
`endif
        meas_clk = 1'b0;
        rst = 1'b0;
        k = 0;
        wd_at = 0;
        early_wd = 0;
        while (wd_at == 0 && k < 1100) begin
            @(negedge clk);
            k++;
            if (clk_ok) early_wd++;
            if (win_done) wd_at = k;
            meas_clk = (k % 20) >= 10;
        end
        check_eq("post_reset_first_win_done", wd_at, 1004);
        check_eq("post_reset_clk_ok_low", early_wd, 0);
        check_eq("post_reset_rst_out", 32'(rst_out), 1);
        check_eq("post_reset_fail", 32'(fail), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
